// File: rtl/register_file_dbg.sv
// -----------------------------------------------------------------------------
// register_file_dbg
//   General-purpose register file with one write port, two independently
//   gated combinational read ports (A/B), optional write-to-read bypass, a
//   debug display port driven by a manual / auto-scan / freeze FSM, and
//   per-register sticky "written" flags.
//
// Ports
//   i_w_clk, i_w_rst_n           clock (posedge), async active-low reset
//   i_w_in, i_w_wr_address,
//   i_w_we                       write port
//   i_w_rd_address_a/b,
//   i_w_oe_a/b, o_w_out_a/b      read ports (zero when not enabled)
//   i_w_disp_address,
//   i_w_disp_mode                display control (00 man, 01 scan, 10 freeze)
//   o_w_disp_out, o_w_disp_index displayed value and index
//   o_w_written, i_w_clr_written sticky written flags and their clear
// -----------------------------------------------------------------------------
module register_file_dbg #(
  parameter int unsigned p_data_width    = 16,
  parameter int unsigned p_address_width = 3,
  parameter int unsigned p_scan_div      = 4,
  parameter bit          p_bypass        = 1'b1
) (
  input  logic                          i_w_clk,
  input  logic                          i_w_rst_n,
  input  logic [p_data_width-1:0]       i_w_in,
  input  logic [p_address_width-1:0]    i_w_wr_address,
  input  logic                          i_w_we,
  input  logic [p_address_width-1:0]    i_w_rd_address_a,
  input  logic                          i_w_oe_a,
  output logic [p_data_width-1:0]       o_w_out_a,
  input  logic [p_address_width-1:0]    i_w_rd_address_b,
  input  logic                          i_w_oe_b,
  output logic [p_data_width-1:0]       o_w_out_b,
  input  logic [p_address_width-1:0]    i_w_disp_address,
  input  logic [1:0]                    i_w_disp_mode,
  output logic [p_data_width-1:0]       o_w_disp_out,
  output logic [p_address_width-1:0]    o_w_disp_index,
  output logic [2**p_address_width-1:0] o_w_written,
  input  logic                          i_w_clr_written
);

  localparam int unsigned lp_depth = 2 ** p_address_width;
  localparam int unsigned lp_div_w = (p_scan_div > 1) ? $clog2(p_scan_div) : 1;
  localparam logic [lp_div_w-1:0] lp_div_last = lp_div_w'(p_scan_div - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_SCAN   = 2'b01,
    ST_FREEZE = 2'b10
  } state_e;

  logic [p_data_width-1:0]    mem_q [lp_depth];
  logic [p_data_width-1:0]    mem_d [lp_depth];
  logic [lp_depth-1:0]        written_q, written_d;
  state_e                     state_q, state_d;
  logic [p_address_width-1:0] index_q, index_d;
  logic [lp_div_w-1:0]        div_q, div_d;
  logic [p_data_width-1:0]    snap_q, snap_d;

  // Shared read-port behaviour: gated by oe, optional same-cycle bypass.
  // Outputs are also forced to zero while reset is asserted, so a bypassed
  // write presented during reset never reaches the read ports.
  function automatic logic [p_data_width-1:0] read_port(
    input logic                       rst_n,
    input logic                       oe,
    input logic [p_address_width-1:0] rd_addr,
    input logic [p_data_width-1:0]    stored
  );
    if (!rst_n || !oe) return '0;
    if (p_bypass && i_w_we && (rd_addr == i_w_wr_address)) return i_w_in;
    return stored;
  endfunction

  assign o_w_out_a = read_port(i_w_rst_n, i_w_oe_a, i_w_rd_address_a, mem_q[i_w_rd_address_a]);
  assign o_w_out_b = read_port(i_w_rst_n, i_w_oe_b, i_w_rd_address_b, mem_q[i_w_rd_address_b]);

  // Storage and written flags. A write in the same cycle as a clear wins for
  // its own bit because the set is applied after the clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    mem_d     = mem_q;
    written_d = i_w_clr_written ? '0 : written_q;
    if (i_w_we) begin
      mem_d[i_w_wr_address]     = i_w_in;
      written_d[i_w_wr_address] = 1'b1;
    end
  end

  // Display FSM: the next state is simply the decoded mode, and entry into a
  // mode is detected by comparing against the current state.
  always_comb begin
    state_d = ST_MANUAL;
    index_d = index_q;
    div_d   = div_q;
    snap_d  = snap_q;
    unique case (i_w_disp_mode)
      2'b01:   state_d = ST_SCAN;
      2'b10:   state_d = ST_FREEZE;
      default: state_d = ST_MANUAL;
    endcase

    unique case (state_d)
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          div_d = '0;                    // entry: keep index, restart divider
        end else if (div_q == lp_div_last) begin
          div_d   = '0;
          index_d = index_q + p_address_width'(1);   // wraps naturally
        end else begin
          div_d = div_q + lp_div_w'(1);
        end
      end
      ST_FREEZE: begin
        // Snapshot uses the stored value, never the bypassed write data.
        if (state_q != ST_FREEZE) snap_d = mem_q[index_q];
      end
      default: begin
        index_d = i_w_disp_address;
        div_d   = '0;
      end
    endcase
  end

  assign o_w_disp_out   = (state_q == ST_FREEZE) ? snap_q : mem_q[index_q];
  assign o_w_disp_index = index_q;
  assign o_w_written    = written_q;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) state_q <= ST_MANUAL;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      // NOTE: the register array is real flops that must read zero after
      // reset, so it is reset here; a RAM macro could not be reset this way.
      for (int i = 0; i < lp_depth; i++) mem_q[i] <= '0;
      written_q <= '0;
      index_q   <= '0;
      div_q     <= '0;
      snap_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before the edge.
      mem_q     <= mem_d;
      written_q <= written_d;
      index_q   <= index_d;
      div_q     <= div_d;
      snap_q    <= snap_d;
    end
  end

endmodule

// File: tb/tb_register_file_dbg.sv
// -----------------------------------------------------------------------------
// tb_register_file_dbg
//   Self-checking bench for register_file_dbg. A behavioural model (arrays,
//   scan position derived from elapsed cycles since scan entry) predicts every
//   output; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_register_file_dbg;

  localparam int P_DW    = 16;
  localparam int P_AW    = 3;
  localparam int P_DIV   = 4;
  localparam bit P_BYP   = 1'b1;
  localparam int P_DEPTH = 2 ** P_AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [P_DW-1:0]   w_in;
  logic [P_AW-1:0]   wr_addr, rd_a, rd_b, disp_addr;
  logic              we, oe_a, oe_b, clr;
  logic [1:0]        disp_mode;
  logic [P_DW-1:0]   out_a, out_b, disp_out;
  logic [P_AW-1:0]   disp_index;
  logic [P_DEPTH-1:0] written;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [P_DW-1:0]    ref_mem [P_DEPTH];
  logic [P_DEPTH-1:0] ref_written;
  int                 ref_state;     // 0 manual, 1 scan, 2 freeze
  int                 ref_idx, scan_base, scan_cnt;
  logic [P_DW-1:0]    ref_snap;

  register_file_dbg #(
    .p_data_width(P_DW), .p_address_width(P_AW),
    .p_scan_div(P_DIV), .p_bypass(P_BYP)
  ) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n),
    .i_w_in(w_in), .i_w_wr_address(wr_addr), .i_w_we(we),
    .i_w_rd_address_a(rd_a), .i_w_oe_a(oe_a), .o_w_out_a(out_a),
    .i_w_rd_address_b(rd_b), .i_w_oe_b(oe_b), .o_w_out_b(out_b),
    .i_w_disp_address(disp_addr), .i_w_disp_mode(disp_mode),
    .o_w_disp_out(disp_out), .o_w_disp_index(disp_index),
    .o_w_written(written), .i_w_clr_written(clr)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < P_DEPTH; i++) ref_mem[i] = '0;
    ref_written = '0;
    ref_state = 0; ref_idx = 0; scan_base = 0; scan_cnt = 0;
    ref_snap = '0;
  endtask

  function automatic logic [P_DW-1:0] exp_read(input logic [P_AW-1:0] a, input logic oe);
    if (!rst_n || !oe) return '0;
    if (P_BYP && we && a == wr_addr) return w_in;
    return ref_mem[a];
  endfunction

  function automatic logic [P_DW-1:0] exp_disp();
    return (ref_state == 2) ? ref_snap : ref_mem[ref_idx];
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    int m;
    m = (disp_mode == 2'b01) ? 1 : (disp_mode == 2'b10) ? 2 : 0;
    if (m == 0) begin
      ref_idx = int'(disp_addr);
    end else if (m == 1) begin
      if (ref_state != 1) begin scan_base = ref_idx; scan_cnt = 0; end
      else scan_cnt++;
      ref_idx = (scan_base + scan_cnt / P_DIV) % P_DEPTH;
    end else if (ref_state != 2) begin
      ref_snap = ref_mem[ref_idx];
    end
    ref_state = m;
    if (clr) ref_written = '0;
    if (we) begin
      ref_written[wr_addr] = 1'b1;
      ref_mem[wr_addr] = w_in;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_in = '0; wr_addr = '0; we = 1'b0; clr = 1'b0;
    rd_a = '0; rd_b = '0; oe_a = 1'b0; oe_b = 1'b0;
    disp_addr = '0; disp_mode = 2'b00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    oe_a = 1'b1; oe_b = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (out_a !== '0)      begin failures++; $display("FAIL reset_out_a: got %h want 0", out_a); end
    checks++; if (out_b !== '0)      begin failures++; $display("FAIL reset_out_b: got %h want 0", out_b); end
    checks++; if (disp_out !== '0)   begin failures++; $display("FAIL reset_disp_out: got %h want 0", disp_out); end
    checks++; if (disp_index !== '0) begin failures++; $display("FAIL reset_disp_index: got %h want 0", disp_index); end
    checks++; if (written !== '0)    begin failures++; $display("FAIL reset_written: got %h want 0", written); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
  endtask

  task automatic test_write_bypass();
    wr_addr = 3'd3; w_in = 16'h1234; we = 1'b1;
    rd_a = 3'd3; oe_a = 1'b1; oe_b = 1'b0; rd_b = 3'd3;
    #1;
    checks++; if (out_a !== exp_read(rd_a, oe_a) || out_a !== 16'h1234)
      begin failures++; $display("FAIL bypass_a: got %h want %h", out_a, 16'h1234); end
    step();
    we = 1'b0;
    #1;
    checks++; if (written !== ref_written || written !== 8'h08)
      begin failures++; $display("FAIL written_r3: got %h want %h", written, ref_written); end
    checks++; if (out_b !== 16'h0000)
      begin failures++; $display("FAIL out_b_gated: got %h want 0", out_b); end
    checks++; if (out_a !== 16'h1234)
      begin failures++; $display("FAIL stored_r3: got %h want 1234", out_a); end
  endtask

  task automatic test_dual_read();
    we = 1'b1; wr_addr = 3'd5; w_in = 16'hAAAA; step();
    wr_addr = 3'd6; w_in = 16'h5555; step();
    we = 1'b0;
    rd_a = 3'd5; rd_b = 3'd6; oe_a = 1'b1; oe_b = 1'b1;
    #1;
    checks++; if (out_a !== exp_read(rd_a, oe_a)) begin failures++; $display("FAIL dual_a: got %h want %h", out_a, exp_read(rd_a, oe_a)); end
    checks++; if (out_b !== exp_read(rd_b, oe_b)) begin failures++; $display("FAIL dual_b: got %h want %h", out_b, exp_read(rd_b, oe_b)); end
    rd_b = 3'd5;
    #1;
    checks++; if (out_b !== 16'hAAAA) begin failures++; $display("FAIL same_addr_b: got %h want aaaa", out_b); end
    oe_a = 1'b0;
    #1;
    checks++; if (out_a !== '0) begin failures++; $display("FAIL oe_a_drop: got %h want 0", out_a); end
    oe_b = 1'b0;
  endtask

  task automatic test_scan();
    we = 1'b1; wr_addr = 3'd7; w_in = 16'h7777; step();
    wr_addr = 3'd0; w_in = 16'h0F0F; step();
    we = 1'b0;
    disp_mode = 2'b00; disp_addr = 3'd6; step();
    checks++; if (disp_index !== 3'd6) begin failures++; $display("FAIL manual_idx6: got %0d want 6", disp_index); end
    disp_mode = 2'b01;
    step();                                   // entry edge
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if (disp_index !== P_AW'(ref_idx))
        begin failures++; $display("FAIL scan_idx c=%0d: got %0d want %0d", c, disp_index, ref_idx); end
      checks++; if (disp_out !== exp_disp())
        begin failures++; $display("FAIL scan_out c=%0d: got %h want %h", c, disp_out, exp_disp()); end
    end
    checks++; if (disp_index !== 3'd0) begin failures++; $display("FAIL scan_wrap: got %0d want 0", disp_index); end
    disp_mode = 2'b00;
  endtask

  task automatic test_freeze();
    disp_mode = 2'b00; disp_addr = 3'd2;
    we = 1'b1; wr_addr = 3'd2; w_in = 16'h00FF; step();
    we = 1'b0; step();
    checks++; if (disp_out !== 16'h00FF) begin failures++; $display("FAIL manual_r2: got %h want 00ff", disp_out); end
    disp_mode = 2'b10; step();
    checks++; if (disp_out !== exp_disp()) begin failures++; $display("FAIL freeze_entry: got %h want %h", disp_out, exp_disp()); end
    we = 1'b1; w_in = 16'hBEEF; step();
    we = 1'b0;
    checks++; if (disp_out !== 16'h00FF) begin failures++; $display("FAIL freeze_hold: got %h want 00ff", disp_out); end
    disp_mode = 2'b00; step();
    checks++; if (disp_out !== 16'hBEEF) begin failures++; $display("FAIL freeze_exit: got %h want beef", disp_out); end
  endtask

  task automatic test_written_clear();
    we = 1'b1;
    for (int i = 0; i < P_DEPTH; i++) begin
      wr_addr = P_AW'(i); w_in = P_DW'($urandom); step();
    end
    checks++; if (written !== 8'hFF) begin failures++; $display("FAIL written_all: got %h want ff", written); end
    clr = 1'b1; wr_addr = 3'd1; step();
    clr = 1'b0; we = 1'b0;
    checks++; if (written !== ref_written || written !== 8'h02)
      begin failures++; $display("FAIL clr_write_wins: got %h want 02", written); end
    clr = 1'b1; step();
    clr = 1'b0;
    checks++; if (written !== '0) begin failures++; $display("FAIL clr_only: got %h want 0", written); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      w_in = P_DW'($urandom); wr_addr = P_AW'($urandom); we = ($urandom_range(1, 0) == 1);
      rd_a = P_AW'($urandom); rd_b = P_AW'($urandom);
      if ($urandom_range(3, 0) == 0) rd_a = wr_addr;
      oe_a = ($urandom_range(3, 0) != 0); oe_b = ($urandom_range(3, 0) != 0);
      clr = ($urandom_range(19, 0) == 0);
      disp_addr = P_AW'($urandom);
      if ($urandom_range(11, 0) == 0) disp_mode = 2'($urandom);
      #1;
      checks++; if (out_a !== exp_read(rd_a, oe_a))
        begin failures++; errs++; if (errs < 10) $display("FAIL rnd_out_a n=%0d: got %h want %h", n, out_a, exp_read(rd_a, oe_a)); end
      checks++; if (out_b !== exp_read(rd_b, oe_b))
        begin failures++; errs++; if (errs < 10) $display("FAIL rnd_out_b n=%0d: got %h want %h", n, out_b, exp_read(rd_b, oe_b)); end
      step();
      checks++; if (disp_index !== P_AW'(ref_idx))
        begin failures++; errs++; if (errs < 10) $display("FAIL rnd_idx n=%0d: got %0d want %0d", n, disp_index, ref_idx); end
      checks++; if (disp_out !== exp_disp())
        begin failures++; errs++; if (errs < 10) $display("FAIL rnd_disp n=%0d: got %h want %h", n, disp_out, exp_disp()); end
      checks++; if (written !== ref_written)
        begin failures++; errs++; if (errs < 10) $display("FAIL rnd_written n=%0d: got %h want %h", n, written, ref_written); end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    we = 1'b1; wr_addr = 3'd4; w_in = 16'h4444; step();
    we = 1'b0;
    disp_mode = 2'b00; disp_addr = 3'd3; step();
    disp_mode = 2'b01;
    repeat (6) step();                        // mid-scan, index already stepped
    #3;                                       // between edges
    rst_n = 1'b0;
    we = 1'b1; wr_addr = 3'd4; w_in = 16'hCAFE;
    rd_a = 3'd4; rd_b = 3'd4; oe_a = 1'b1; oe_b = 1'b1;
    #1;
    checks++; if (out_a !== '0)      begin failures++; $display("FAIL async_out_a: got %h want 0", out_a); end
    checks++; if (out_b !== '0)      begin failures++; $display("FAIL async_out_b: got %h want 0", out_b); end
    checks++; if (disp_out !== '0)   begin failures++; $display("FAIL async_disp_out: got %h want 0", disp_out); end
    checks++; if (disp_index !== '0) begin failures++; $display("FAIL async_disp_index: got %h want 0", disp_index); end
    checks++; if (written !== '0)    begin failures++; $display("FAIL async_written: got %h want 0", written); end
    model_reset();
    @(posedge clk);
    #2;
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (disp_index !== '0) begin failures++; $display("FAIL release_idx: got %0d want 0", disp_index); end
    oe_a = 1'b1; rd_a = 3'd4;
    #1;
    checks++; if (out_a !== '0) begin failures++; $display("FAIL release_r4_cleared: got %h want 0", out_a); end
    // Mode still scan: the first edge after release is a scan entry from MANUAL.
    step();
    checks++; if (disp_index !== P_AW'(ref_idx)) begin failures++; $display("FAIL post_reset_idx: got %0d want %0d", disp_index, ref_idx); end
    repeat (P_DIV) step();
    checks++; if (disp_index !== P_AW'(ref_idx)) begin failures++; $display("FAIL post_reset_step: got %0d want %0d", disp_index, ref_idx); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_dual_read();
    test_scan();
    test_freeze();
    test_written_clear();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_dbg.md
Name: register_file_dbg

Overview:
Parametrised successor to the CPU general-purpose register file.
- One write port and two independent gated read ports, A and B, so the ALU can fetch both operands in one cycle.
- Optional write-to-read bypass.
- Debug display port driven by a small FSM with three modes: manual, auto-scan and freeze.
- Per-register sticky "written" flags for the debug-mode board display.

Parameters:
p_data_width, 16, width of each register and of all data ports
p_address_width, 3, address width; depth = 2**p_address_width
p_scan_div, 4, clock cycles per auto-scan step (legal range >= 1)
p_bypass, 1, 1 = read port returns i_w_in when reading the address being written that cycle; 0 = read returns stored value

Ports:
i_w_clk  input  1  clock; all state updates on posedge
i_w_rst_n  input  1  asynchronous active-low reset
i_w_in  input  p_data_width  write data
i_w_wr_address  input  p_address_width  write address
i_w_we  input  1  write enable
i_w_rd_address_a  input  p_address_width  read port A address
i_w_oe_a  input  1  read port A output enable
o_w_out_a  output  p_data_width  read port A data
i_w_rd_address_b  input  p_address_width  read port B address
i_w_oe_b  input  1  read port B output enable
o_w_out_b  output  p_data_width  read port B data
i_w_disp_address  input  p_address_width  manual display address
i_w_disp_mode  input  2  00 manual, 01 auto-scan, 10 freeze, 11 treated as manual
o_w_disp_out  output  p_data_width  displayed register value
o_w_disp_index  output  p_address_width  index currently displayed
o_w_written  output  2**p_address_width  bit k = register k written since reset/clear
i_w_clr_written  input  1  synchronous clear of all written flags

Behaviour:
Reset (i_w_rst_n low, takes effect immediately, independent of clock):
- All registers, display index, scan divider, snapshot and written flags go to 0; FSM goes to MANUAL.
- o_w_out_a/b = 0, o_w_disp_out = 0, o_w_disp_index = 0, o_w_written = 0.
- A write or scan in progress when reset asserts is discarded.

Write port:
- When i_w_we=1, i_w_in is stored at i_w_wr_address on posedge.
- Writes are not blocked by i_w_oe_a/b; this differs from the previous generation.

Read ports:
- Combinational, zero latency.
- o_w_out_x = stored[rd_address_x] when oe_x=1, else all zeros.
- p_bypass=1, we=1, rd_address_x == wr_address and oe_x=1: o_w_out_x = i_w_in in the same cycle.
- Both ports may read the same address simultaneously.

Written flags:
- Bit set on the posedge that writes that register.
- i_w_clr_written clears all bits on posedge.
- clr and we in the same cycle: all bits clear except bit[wr_address], which is set (write wins).

Display FSM, evaluated on posedge from i_w_disp_mode:
- MANUAL:
  - Index register loads i_w_disp_address each cycle, so the display follows the address with 1-cycle latency.
  - Divider held at 0.
- SCAN:
  - Divider counts 0..p_scan_div-1.
  - At terminal count, index increments and divider returns to 0.
  - Index wraps from 2**p_address_width-1 to 0.
  - Entry from any state keeps the current index, clears the divider, and takes the first step p_scan_div cycles after entry.
  - p_scan_div=1 steps every cycle.
- FREEZE:
  - On the entry cycle the snapshot register captures stored[index] (bypass not applied).
  - Index and divider are held.
  - o_w_disp_out = snapshot while in FREEZE, even if that register is later written.
  - Leaving FREEZE resumes normal output on the next cycle.
- Transitions are direct between any two modes on a mode change.

Display output:
- o_w_disp_out = stored[index] combinationally in MANUAL/SCAN; no bypass on the display path.
- o_w_disp_index = index register.

Test Plan:
- Reset, then write 0x1234 to r3 with oe_a=1, rd_a=3, p_bypass=1 -> o_w_out_a=0x1234 in the write cycle; after the edge o_w_written=0x08 and o_w_out_b=0 while oe_b=0.
- Write r5=0xAAAA, r6=0x5555; read A=5, B=6 simultaneously -> 0xAAAA / 0x5555; drop oe_a -> o_w_out_a=0.
- Auto-scan with p_scan_div=4 from index 6 -> index 7 after 4 cycles, 0 after 8 (wrap); o_w_disp_out tracks register contents.
- Manual disp_address=2 holding 0x00FF, switch to freeze, write r2=0xBEEF -> o_w_disp_out stays 0x00FF; return to manual -> 0xBEEF next cycle.
- clr_written together with a write to r1 when flags=0xFF -> o_w_written=0x02.
- Assert i_w_rst_n=0 mid-scan between clock edges -> all outputs 0 immediately, FSM in MANUAL, index 0 after release.
